add_m: RTL and testbench

//   Lane-wise signed adder for the matrix coprocessor datapath.

---
 rtl/add_m.sv | 74 +++++++
 tb/tb_add_m.sv | 131 +++++++++++++
 2 files changed

// File: rtl/add_m.sv
`default_nettype none
// ============================================================================
// Module   : add_m
// Brief    : Lane-wise signed adder for packed rows with wrap and overflow.
// Revision : 1.0  initial release
// ============================================================================

module add_m #(
   parameter int ELEM_W = 8,
   parameter int N_ELEM = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [ELEM_W*N_ELEM-1:0]   m1,
   input  logic [ELEM_W*N_ELEM-1:0]   m2,
   output logic [ELEM_W*N_ELEM-1:0]   m_out,
   output logic                       ovf,
   output logic [N_ELEM-1:0]          ovf_lane,
   output logic                       out_valid
);

   localparam int W = ELEM_W * N_ELEM;

   logic [W-1:0]      w_sum_row;
   logic [N_ELEM-1:0] w_ovf_lane;

   logic [W-1:0]      r_m_out;
   logic              r_ovf;
   logic [N_ELEM-1:0] r_ovf_lane;
   logic              r_out_valid;

   // Lane 0 sits at the MSB end; ovf_lane keeps the same ordering so that the
   // written binary value reads lane 0 first.
   for (genvar i = 0; i < N_ELEM; i++) begin : g_lane
      localparam int HI = W - 1 - i * ELEM_W;

      logic [ELEM_W-1:0] w_a;
      logic [ELEM_W-1:0] w_b;
      logic [ELEM_W:0]   w_s;

      assign w_a = m1[HI -: ELEM_W];
      assign w_b = m2[HI -: ELEM_W];
      assign w_s = {w_a[ELEM_W-1], w_a} + {w_b[ELEM_W-1], w_b};

      assign w_sum_row[HI -: ELEM_W]  = w_s[ELEM_W-1:0];
      // Sign-extended sum disagrees in its top two bits only on true overflow.
      assign w_ovf_lane[N_ELEM-1-i]   = w_s[ELEM_W] ^ w_s[ELEM_W-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_m_out     <= '0;
         r_ovf       <= 1'b0;
         r_ovf_lane  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_m_out    <= w_sum_row;
            r_ovf      <= |w_ovf_lane;
            r_ovf_lane <= w_ovf_lane;
         end
      end
   end

   assign m_out     = r_m_out;
   assign ovf       = r_ovf;
   assign ovf_lane  = r_ovf_lane;
   assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_add_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_m
// Brief    : Directed self-checking bench for add_m.
// Revision : 1.0  initial release
// ============================================================================

module tb_add_m;

   localparam int ELEM_W = 8;
   localparam int N_ELEM = 5;
   localparam int W      = ELEM_W * N_ELEM;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [W-1:0]      m1;
   logic [W-1:0]      m2;
   logic [W-1:0]      m_out;
   logic              ovf;
   logic [N_ELEM-1:0] ovf_lane;
   logic              out_valid;

   int n_checks = 0;
   int n_pass   = 0;

   add_m #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .m1        (m1),
      .m2        (m2),
      .m_out     (m_out),
      .ovf       (ovf),
      .ovf_lane  (ovf_lane),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] row(input int e0, input int e1, input int e2,
                                        input int e3, input int e4);
      return {e0[7:0], e1[7:0], e2[7:0], e3[7:0], e4[7:0]};
   endfunction

   task automatic check_out(input string tag, input logic [W-1:0] exp_m,
                            input logic exp_ovf, input logic [N_ELEM-1:0] exp_lane,
                            input logic exp_valid);
      check({tag, ".m_out"},     m_out,     exp_m);
      check({tag, ".ovf"},       ovf,       exp_ovf);
      check({tag, ".ovf_lane"},  ovf_lane,  exp_lane);
      check({tag, ".out_valid"}, out_valid, exp_valid);
   endtask

   // One isolated operation: drive at negedge, sample just after the capturing edge.
   task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_m, input logic exp_ovf,
                            input logic [N_ELEM-1:0] exp_lane);
      @(negedge clk);
      m1 = a; m2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      check_out(tag, exp_m, exp_ovf, exp_lane, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, ".drop"}, out_valid, 1'b0);
   endtask

   logic [W-1:0] a2, b2, a3, b3, a4, b4;

   initial begin
      a2 = row(10, 20, 30, 40, 50);    b2 = row(5, 15, 25, 35, 45);
      a3 = row(10, -20, 30, -40, 50);  b3 = row(-5, 15, -25, 35, -45);
      a4 = row(100, -100, 127, -128, 50); b4 = row(30, 30, 1, -1, -100);

      // Reset held with busy random inputs
      rst = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m1 = {$urandom, $urandom}; m2 = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      check_out("reset", '0, 1'b0, '0, 1'b0);

      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      check("idle.out_valid", out_valid, 1'b0);

      single_op("pos",   a2, b2, 40'h0F23374B5F, 1'b0, 5'b00000);
      single_op("mixed", a3, b3, 40'h05FB05FB05, 1'b0, 5'b00000);
      single_op("ovf",   a4, b4, 40'h82BA807FCE, 1'b1, 5'b10110);
      single_op("carry", {5{8'hFF}}, {5{8'h01}}, '0, 1'b0, 5'b00000);
      single_op("minmin", {5{8'h80}}, {5{8'h80}}, '0, 1'b1, 5'b11111);

      // Back-to-back stream, then hold
      @(negedge clk); m1 = a2; m2 = b2; in_valid = 1'b1;
      @(posedge clk); #1; check_out("s2", 40'h0F23374B5F, 1'b0, 5'b00000, 1'b1);
      @(negedge clk); m1 = a3; m2 = b3;
      @(posedge clk); #1; check_out("s3", 40'h05FB05FB05, 1'b0, 5'b00000, 1'b1);
      @(negedge clk); m1 = a4; m2 = b4;
      @(posedge clk); #1; check_out("s4", 40'h82BA807FCE, 1'b1, 5'b10110, 1'b1);
      @(negedge clk); m1 = a2; m2 = b2; in_valid = 1'b0;
      @(posedge clk); #1; check_out("hold", 40'h82BA807FCE, 1'b1, 5'b10110, 1'b0);
      @(posedge clk); #1; check_out("hold2", 40'h82BA807FCE, 1'b1, 5'b10110, 1'b0);

      // Asynchronous reset mid-run clears at once, away from any edge
      @(negedge clk); m1 = a2; m2 = b2; in_valid = 1'b1;
      @(posedge clk); #1; check("pre_rst.out_valid", out_valid, 1'b1);
      #2 rst = 1'b0;
      #1 check_out("async_rst", '0, 1'b0, '0, 1'b0);
      @(posedge clk); #1; check_out("rst_held", '0, 1'b0, '0, 1'b0);

      // First edge after release with in_valid produces a fresh result
      @(negedge clk); rst = 1'b1; m1 = a3; m2 = b3; in_valid = 1'b1;
      @(posedge clk); #1; check_out("post_rst", 40'h05FB05FB05, 1'b0, 5'b00000, 1'b1);
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
